// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// bit-timing helpers used by both the RX and TX sides.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  localparam int          DATA_BITS        = 8;
  localparam logic [15:0] MIN_CLKS_PER_BIT = 16'd4;

  function automatic logic [15:0] half_period(input logic [15:0] clks);
    return clks >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input, with a
// parameterised reset value so it can sit on any idle-high or idle-low pad.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], i_D};
    end
  end

  assign o_Q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with programmable bit period, holding register with
// valid/read handshake, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [15:0] i_ClksPerBit,
  input  logic        i_UART_RX,
  input  logic        i_RxRead,
  output logic [7:0]  o_RxData,
  output logic        o_RxValid,
  output logic        o_Overrun,
  output logic        o_FrameErr,
  output logic        o_RxIdle
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        deliver;
  logic [15:0] bit_end;
  logic [15:0] half_end;

  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_UART_RX),
    .o_Q     (rx_s)
  );

  assign bit_end  = i_ClksPerBit - 16'd1;
  assign half_end = half_period(i_ClksPerBit) - 16'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = 16'd0;
        bit_d = 3'd0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == half_end) begin
          cnt_d   = 16'd0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == bit_end) begin
          cnt_d   = 16'd0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = 3'd0;
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop-bit keeps a back-to-back start edge catchable.
        if (cnt_q == bit_end) begin
          cnt_d = 16'd0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_BREAK: begin
        cnt_d = 16'd0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // A delivery in the same cycle as a read wins and does not count as overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (deliver) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (i_RxRead) begin
        ovr_d = 1'b0;
      end else if (valid_q) begin
        ovr_d = 1'b1;
      end
    end else if (i_RxRead) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign o_RxData   = data_q;
  assign o_RxValid  = valid_q;
  assign o_Overrun  = ovr_q;
  assign o_FrameErr = ferr_q;
  assign o_RxIdle   = (state_q == RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, expected bytes
// are queued at send time and compared when the receiver presents them.
module tb_uart_rx;

  logic        clk;
  logic        rst_n;
  logic [15:0] clks_per_bit;
  logic        uart;
  logic        rd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;
  logic        rx_idle;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          rise_cyc;
  int          start_cyc;
  int          ferr_cnt;
  int          ferr_before;
  bit          auto_read;
  bit          saw_busy;
  logic [8:0]  exp_q[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_ClksPerBit (clks_per_bit),
    .i_UART_RX    (uart),
    .i_RxRead     (rd),
    .o_RxData     (rx_data),
    .o_RxValid    (rx_valid),
    .o_Overrun    (overrun),
    .o_FrameErr   (frame_err),
    .o_RxIdle     (rx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: a delivery is a rising o_RxValid or new data while valid.
  initial begin
    logic       prev_v;
    logic [7:0] prev_d;
    logic [8:0] exp;
    prev_v = 1'b0;
    prev_d = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_d = 8'd0;
      end else begin
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (!rx_idle) saw_busy = 1'b1;
        if (rx_valid && (!prev_v || rx_data != prev_d)) begin
          rise_cyc = cyc;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
          chk("rx_data", {23'd0, 1'b0, rx_data}, {23'd0, exp});
        end
        prev_v = rx_valid;
        prev_d = rx_data;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (auto_read) rd = rx_valid && !rd;
    else           rd = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first and stop; abort_tick>=0 asserts reset mid-frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit push,
                            input int abort_tick);
    logic [9:0] bits;
    int t;
    bits = {stop_v, b, 1'b0};
    t = 0;
    if (push) exp_q.push_back({1'b0, b});
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart = bits[i];
      for (int j = 0; j < int'(clks_per_bit); j++) begin
        if (t == abort_tick) begin
          rst_n = 1'b0;
          return;
        end
        tick();
        t++;
      end
    end
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    uart = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; rise_cyc = 0; start_cyc = 0;
    ferr_cnt = 0; auto_read = 0; saw_busy = 0;
    rst_n = 1'b0; uart = 1'b1; rd = 1'b0; clks_per_bit = 16'd16;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_idle", rx_idle, 1);
    rst_n = 1'b1;
    idle_ticks(4);

    // Clean frame, latency from the edge that first samples the start bit
    rise_cyc = 0;
    send_frame(8'hA5, 1'b1, 1, -1);
    chk("latency", rise_cyc - (start_cyc + 1), 2 + (16 / 2 - 1) + 9 * 16 + 1);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_no_ferr", ferr_cnt, 0);
    read_pulse();
    chk("a5_read_clr", rx_valid, 0);

    // Back-to-back frames with reads in flight
    auto_read = 1;
    send_frame(8'h00, 1'b1, 1, -1);
    send_frame(8'hFF, 1'b1, 1, -1);
    idle_ticks(32);
    auto_read = 0;
    rd = 1'b0;
    chk("b2b_overrun", overrun, 0);
    chk("b2b_valid", rx_valid, 0);

    // Short low glitch on an idle line
    saw_busy = 0;
    uart = 1'b0;
    repeat (5) tick();
    uart = 1'b1;
    repeat (7) tick();
    chk("glitch_busy", saw_busy, 1);
    chk("glitch_idle", rx_idle, 1);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // Framing error followed by a long break, then a good frame
    ferr_before = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0, -1);
    uart = 1'b0;
    repeat (40 * 16) tick();
    chk("break_busy", rx_idle, 0);
    idle_ticks(32);
    chk("break_one_ferr", ferr_cnt - ferr_before, 1);
    chk("break_valid", rx_valid, 0);
    chk("break_idle", rx_idle, 1);
    send_frame(8'h81, 1'b1, 1, -1);
    idle_ticks(8);
    chk("post_break_data", rx_data, 8'h81);
    chk("post_break_valid", rx_valid, 1);

    // Reset mid-data with an unread byte still held
    send_frame(8'h5A, 1'b1, 0, 60);
    #1;
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_idle", rx_idle, 1);
    uart = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(4);
    send_frame(8'h5A, 1'b1, 1, -1);
    idle_ticks(8);
    chk("after_rst_data", rx_data, 8'h5A);
    chk("after_rst_valid", rx_valid, 1);
    read_pulse();

    // Minimum bit period: overrun, then read coinciding with delivery
    clks_per_bit = 16'd4;
    idle_ticks(4);
    send_frame(8'h11, 1'b1, 1, -1);
    send_frame(8'h22, 1'b1, 1, -1);
    idle_ticks(4);
    chk("ovr_data", rx_data, 8'h22);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun, 1);
    read_pulse();
    chk("ovr_read_valid", rx_valid, 0);
    chk("ovr_read_flag", overrun, 0);
    send_frame(8'h11, 1'b1, 1, -1);
    send_frame(8'h22, 1'b1, 1, -1);
    // The stop sample of the frame just sent lands on the next rising edge.
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    idle_ticks(4);
    chk("coinc_valid", rx_valid, 1);
    chk("coinc_data", rx_data, 8'h22);
    chk("coinc_overrun", overrun, 0);
    read_pulse();
    chk("coinc_read_clr", rx_valid, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
